// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and next-PC select encoding for the MIPS pipeline.
package cpu_pkg;
  localparam int PC_W = 32;
  localparam int INSTR_W = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;
endpackage

// File: rtl/if_stage_npc_sel.sv
// npc_sel: fixed-priority next-PC mux (jr > j > branch > sequential).
module npc_sel
  import cpu_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] id_pc,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [25:0]     instr_index,
  input  logic            jr,
  input  logic [PC_W-1:0] jr_target,
  output logic [PC_W-1:0] npc,
  output npc_sel_e        sel
);
  logic [PC_W-1:0] j_target;
  // j/jal keep the 256MB segment of the delay slot, i.e. of id_pc+4
  assign j_target = ((id_pc + 32'd4) & 32'hF000_0000) | {4'b0, instr_index, 2'b00};
  always_comb begin
    sel = jr ? NPC_JR : jump ? NPC_J : branch_taken ? NPC_BR : NPC_SEQ;
    npc = jr ? jr_target : jump ? j_target : branch_taken ? branch_target : pc + 32'd4;
  end
endmodule

// File: rtl/if_stage.sv
// if_stage: MIPS fetch stage owning the PC and the IF/ID register.
// Delay slots always proceed into ID; there is no flush path.
module if_stage #(
  parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] instr_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic [31:0] imem_instr,
  output logic [31:0] imem_addr,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        id_valid
);
  logic [31:0] pc;
  logic [31:0] npc;
  cpu_pkg::npc_sel_e sel;
  npc_sel u_npc_sel (
    .pc(pc),
    .id_pc(id_pc),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .jump(jump),
    .instr_index(instr_index),
    .jr(jr),
    .jr_target(jr_target),
    .npc(npc),
    .sel(sel)
  );
  assign imem_addr = pc;
  assign id_pc8 = id_pc + 32'd8;
  always_comb assert (reset !== 1'b1 || sel != cpu_pkg::NPC_JR || npc === jr_target);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
      id_instr <= NOP_INSTR;
      id_pc <= RESET_PC;
      id_valid <= 1'b0;
    end else if (!stall) begin
      pc <= npc;
      id_instr <= imem_instr;
      id_pc <= pc;
      id_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed plus random checks of if_stage against a fetch model.
module tb_if_stage;
  logic clk = 0, reset = 1, stall = 0, branch_taken = 0, jump = 0, jr = 0;
  logic [31:0] branch_target = 0, jr_target = 0;
  logic [25:0] instr_index = 0;
  logic [31:0] imem_instr, imem_addr, id_instr, id_pc, id_pc8;
  logic id_valid;
  int errors = 0, checks = 0;
  logic [31:0] m_pc, m_id_pc, m_id_instr;
  logic m_valid;

  always #5 clk = ~clk;

  function automatic logic [31:0] im(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction
  assign imem_instr = im(imem_addr);

  if_stage dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .instr_index(instr_index), .jr(jr), .jr_target(jr_target),
    .imem_instr(imem_instr), .imem_addr(imem_addr), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc8(id_pc8), .id_valid(id_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".addr"}, imem_addr, m_pc);
    chk({tag, ".id_pc"}, id_pc, m_id_pc);
    chk({tag, ".id_instr"}, id_instr, m_id_instr);
    chk({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, m_valid});
    chk({tag, ".id_pc8"}, id_pc8, m_id_pc + 32'd8);
  endtask

  task automatic model_reset;
    m_pc = 32'h3000;
    m_id_pc = 32'h3000;
    m_id_instr = 32'h0;
    m_valid = 1'b0;
  endtask

  // one clock: next PC follows jr > j > branch > pc+4; stall freezes everything
  task automatic step(input string tag, input logic s, input logic b, input logic [31:0] bt,
                      input logic j, input logic [25:0] ix, input logic r, input logic [31:0] rt);
    logic [31:0] n, p4;
    stall = s; branch_taken = b; branch_target = bt;
    jump = j; instr_index = ix; jr = r; jr_target = rt;
    p4 = m_id_pc + 32'd4;
    if (r) n = rt;
    else if (j) n = {p4[31:28], ix, 2'b00};
    else if (b) n = bt;
    else n = m_pc + 32'd4;
    @(posedge clk);
    #1;
    if (!s) begin
      m_id_instr = im(m_pc);
      m_id_pc = m_pc;
      m_pc = n;
      m_valid = 1'b1;
    end
    chk_all(tag);
  endtask

  initial begin
    model_reset();
    #2 reset = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("rst");
    chk("rst.addr_abs", imem_addr, 32'h3000);
    chk("rst.pc8_abs", id_pc8, 32'h3008);
    reset = 1;
    step("seq1", 0, 0, 0, 0, 0, 0, 0);
    chk("first.addr", imem_addr, 32'h3004);
    chk("first.instr", id_instr, im(32'h3000));
    step("seq2", 0, 0, 0, 0, 0, 0, 0);
    step("seq3", 0, 0, 0, 0, 0, 0, 0);
    chk("seq.id_pc", id_pc, 32'h3008);
    step("br", 0, 1, 32'h3040, 0, 0, 0, 0);
    chk("br.addr", imem_addr, 32'h3040);
    chk("br.slot", id_pc, 32'h300C);
    step("br_tgt", 0, 0, 0, 0, 0, 0, 0);
    chk("br_tgt.id_pc", id_pc, 32'h3040);
    step("jr1", 0, 0, 0, 0, 0, 1, 32'h3010);
    step("jr1b", 0, 0, 0, 0, 0, 0, 0);
    chk("j.pre_id_pc", id_pc, 32'h3010);
    step("j", 0, 0, 0, 1, 26'h0000C10, 0, 0);
    chk("j.addr", imem_addr, 32'h3040);
    step("jrj", 0, 0, 0, 1, 26'h0000C10, 1, 32'h3100);
    chk("jrj.addr", imem_addr, 32'h3100);
    step("stall1", 1, 1, 32'h3200, 0, 0, 0, 0);
    step("stall2", 1, 1, 32'h3200, 0, 0, 0, 0);
    chk("stall.addr", imem_addr, 32'h3100);
    step("unstall", 0, 1, 32'h3200, 0, 0, 0, 0);
    chk("unstall.addr", imem_addr, 32'h3200);
    step("to3020", 0, 0, 0, 0, 0, 1, 32'h3020);
    #3 reset = 0;
    #1;
    chk("async.addr", imem_addr, 32'h3000);
    chk("async.valid", {31'b0, id_valid}, 32'h0);
    model_reset();
    chk_all("async");
    #2 reset = 1;
    step("wrap0", 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    step("wrap1", 0, 0, 0, 0, 0, 0, 0);
    chk("wrap.addr", imem_addr, 32'h0);
    chk("wrap.pc8", id_pc8, 32'h4);
    for (int i = 0; i < 300; i++) begin
      step("rnd", ($urandom_range(3) == 0), ($urandom_range(4) == 0), $urandom,
           ($urandom_range(9) == 0), 26'($urandom), ($urandom_range(9) == 0), $urandom);
      if ($urandom_range(49) == 0) begin
        #2 reset = 0;
        #1;
        model_reset();
        chk_all("rnd_rst");
        #1 reset = 1;
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: holds the PC register, selects the next PC, and registers the fetched instruction into the IF/ID pipeline register.
- Consumes redirect information resolved in ID: the branch target from the ID branch-target adder, the jump instr_index, and the jr register value.
- Produces the PC that drives instruction memory, plus id_pc and id_pc8, which feed the ID branch-target adder and the jal link path.
- MIPS delayed-branch semantics: the delay-slot instruction always executes and is never flushed.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded at reset; first fetch address.
- NOP_INSTR, 32'h0000_0000, instruction value id_instr takes at reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hazard-unit stall; holds PC and the IF/ID register.
- branch_taken  in  1  branch instruction in ID resolved taken.
- branch_target  in  32  branch target from the ID adder (sign-extended offset<<2 plus id_pc+4).
- jump  in  1  j/jal in ID.
- instr_index  in  26  instr_index field of the j/jal instruction in ID.
- jr  in  1  jr/jalr in ID.
- jr_target  in  32  forwarded rs value for jr/jalr.
- imem_instr  in  32  instruction word read combinationally from IM at imem_addr.
- imem_addr  out  32  current PC; the IM read address.
- id_instr  out  32  IF/ID registered instruction.
- id_pc  out  32  IF/ID registered PC of id_instr.
- id_pc8  out  32  id_pc + 8; link value for jal/jalr.
- id_valid  out  1  IF/ID holds a real fetched instruction (0 after reset).

Behaviour:
- Reset: while reset==0, asynchronously forces the following:
  - pc=RESET_PC
  - id_instr=NOP_INSTR
  - id_pc=RESET_PC
  - id_valid=0
  - id_pc8 follows id_pc, so it reads RESET_PC+8.
- Reset has effect mid-operation at any time and overrides stall and all redirects.
- imem_addr equals pc combinationally.
- Next-PC selection, with fixed priority when several requests are asserted:
  - jr=1: npc=jr_target.
  - else jump=1: npc={id_pc_plus4[31:28], instr_index, 2'b00}, where id_pc_plus4 = id_pc+4.
  - else branch_taken=1: npc=branch_target.
  - else: npc=pc+4.
- Legal software never asserts more than one redirect; the priority exists only for determinism.
- All PC arithmetic is modulo 2^32. pc=32'hFFFF_FFFC plus 4 wraps to 0, with no flag.
- Rising edge with stall=0:
  - pc<=npc
  - id_instr<=imem_instr
  - id_pc<=pc
  - id_valid<=1
- Rising edge with stall=1:
  - pc, id_instr, id_pc and id_valid all hold.
  - Redirect inputs are ignored that cycle; ID re-evaluates its redirect when the stall releases.
- Latency:
  - A redirect asserted in cycle N, with stall=0, sets pc to the target after edge N.
  - The instruction already fetched in cycle N (the delay slot) enters ID at edge N.
  - The target instruction enters ID at edge N+1.
- No alignment checking; the low two bits of the target pass through unchanged.
- There is no flush input. Delay slots are never squashed.

Decomposition:
- Shared package cpu_pkg holds:
  - RESET_PC_DEFAULT (32'h0000_3000)
  - NOP_INSTR (32'h0)
  - INSTR_W=32, PC_W=32
  - the 2-bit npc_sel encoding: NPC_SEQ=0, NPC_BR=1, NPC_J=2, NPC_JR=3
- One combinational sub-module, npc_sel.
  - Inputs: pc, id_pc, the redirect requests and their targets.
  - Outputs: npc and the 2-bit select code, exposed for debug and assertions.
- if_stage instantiates npc_sel and owns the PC and IF/ID flops.

Test Plan:
- Reset sequencing: hold reset=0 for 3 cycles, then release → imem_addr=32'h3000, id_valid=0, id_pc8=32'h3008 during reset. After the first edge, id_pc=32'h3000, id_instr=IM[0x3000], id_valid=1, imem_addr=32'h3004.
- Sequential fetch: 5 cycles, no stall → imem_addr walks 3000, 3004, 3008, 300C, 3010, and id_pc lags imem_addr by exactly one cycle.
- Taken branch (1):
  - Stimulus: ID holds beq at id_pc=32'h3008; branch_taken=1 with branch_target=32'h3040 for one cycle.
  - Required: next imem_addr=32'h3040, and the delay slot at 32'h300C reaches ID.
- Taken branch (2): the following cycle → id_pc=32'h3040 (target instruction in ID).
- Jump and jr:
  - Jump: with id_pc=32'h3010, jump=1, instr_index=26'h0000C10 → npc=32'h0000_3040.
  - jr: jr=1, jr_target=32'h0000_3100, asserted together with jump=1 → npc=32'h3100 (jr wins).
- Stall: assert stall for 2 cycles while branch_taken=1 → pc, id_pc, id_instr are unchanged across both edges and the redirect is not taken. On release, with branch_taken still 1, pc updates to branch_target.
- Async reset mid-run: drop reset between clock edges at pc=32'h3020 → imem_addr becomes 32'h3000 and id_valid becomes 0 immediately, without a clock edge. Wrap-around case: force pc=32'hFFFF_FFFC → next pc=32'h0.
